rf_psum_drain: RTL
==================

// Module: rf_psum_drain
// PURPOSE
//   Partial-sum register file directly downstream of the PE MAC. Captures MAC results
//   (out / out_en / write_addr), feeds the stored psum back as the MAC's sum_in, and
//   drains all entries to the global buffer over a valid/ready port, clearing each on drain.
// PARAMETERS
//   OUT_BITWIDTH        16  width of each psum entry and of the MAC result
//   PSUM_ADDR_BITWIDTH  2   entry address width; DEPTH = 2**PSUM_ADDR_BITWIDTH
// PORTS
//   clk             in   1                   clock; all state updates on posedge
//   rst             in   1                   reset, synchronous, active-high
//   mac_out         in   OUT_BITWIDTH        MAC result to store
//   mac_out_en      in   1                   write strobe from MAC
//   mac_write_addr  in   PSUM_ADDR_BITWIDTH  entry written by mac_out
//   psum_read_addr  in   PSUM_ADDR_BITWIDTH  entry to present as MAC sum_in
//   sum_out         out  OUT_BITWIDTH        combinational mem[psum_read_addr] -> MAC sum_in
//   drain_start     in   1                   one-cycle request to drain all entries
//   drain_valid     out  1                   drain_data/drain_addr valid
//   drain_data      out  OUT_BITWIDTH        entry content being drained
//   drain_addr      out  PSUM_ADDR_BITWIDTH  index of entry being drained
//   drain_ready     in   1                   global buffer accepts current entry
//   drain_busy      out  1                   high in DRAIN state
//   drain_done      out  1                   one-cycle pulse after last entry accepted
//   wr_drop         out  1                   sticky: a MAC write was discarded during drain
// BEHAVIOUR
//   - Reset: all DEPTH entries = 0; state IDLE; ptr = 0; drain_valid, drain_busy,
//     drain_done, wr_drop = 0. rst mid-drain aborts it: no done pulse, entries zeroed.
//   - Write: posedge with mac_out_en=1 and state IDLE -> mem[mac_write_addr] <= mac_out.
//     Data is a straight overwrite (accumulation is done by the MAC); no width change.
//   - Read: sum_out = mem[psum_read_addr], zero-latency combinational.
//   - FSM IDLE -> DRAIN: posedge with drain_start=1 in IDLE; ptr <= 0. A MAC write on the
//     same edge is committed, so the drain sees it. drain_start ignored outside IDLE.
//   - DRAIN: drain_valid=1, drain_addr=ptr, drain_data=mem[ptr] (combinational).
//     On posedge with drain_ready=1: mem[ptr] <= 0; ptr++; if ptr==DEPTH-1 -> DONE.
//     drain_ready=0 holds ptr/data stable (valid must not drop without handshake).
//   - DONE: one cycle; drain_done=1, drain_valid=0, drain_busy=0; next state IDLE.
//     DEPTH accepted entries take exactly DEPTH handshake cycles + 1 DONE cycle.
//   - MAC write while in DRAIN or DONE: discarded, wr_drop <= 1 (cleared only by rst).
//   - sum_out remains readable during drain (reflects cleared entries immediately).
//   - Out-of-range addresses impossible (DEPTH is power of 2); ptr wraps to 0 in DONE.
// CONFIGURATION
//   RF_PSUM_BYPASS_EN defined: if mac_out_en=1 in IDLE and mac_write_addr==psum_read_addr,
//     sum_out = mac_out in that cycle (write-to-read forwarding for back-to-back
//     accumulation into the same entry). Same forwarding applies to drain_data is NOT
//     done (drain never coincides with accepted writes).
//   Undefined: sum_out always shows the stored value; new data visible from next cycle.
// TESTING
//   1 rst=1 one edge after random writes -> all entries read 0, wr_drop=0, drain_valid=0.
//   2 write 5@0, 7@3 (mac_out_en pulses); read addr 3 -> sum_out=7; addr 0 -> 5; addr 1 -> 0.
//   3 entries {5,0,0,7}, drain_start, drain_ready=1 -> data 5,0,0,7 at addr 0..3 on
//     4 consecutive cycles, drain_done pulse cycle 5, all entries 0 afterwards.
//   4 drain with drain_ready toggling 1,0,0,1,... -> data/addr held while ready=0,
//     no entry skipped or duplicated; MAC write during drain -> discarded, wr_drop=1.
//   5 drain_start and write 9@2 same edge -> drained entry 2 = 9.
//   6 BYPASS_EN: write 11@1 with psum_read_addr=1 same cycle -> sum_out=11 that cycle
//     (without macro: old value, 11 next cycle); rst in mid-drain -> IDLE, no done pulse.

Source files
------------

// File: rtl/rf_psum_drain.sv
// rf_psum_drain -- partial-sum register file sitting right after the PE MAC.
//
// Captures MAC results, feeds the stored psum back to the MAC as sum_in, and
// drains every entry to the global buffer over a valid/ready port. Each entry
// is cleared as it is accepted.
//
// Optional feature (macro RF_PSUM_BYPASS_EN):
//   defined   -> a write that targets the entry being read is forwarded to
//                sum_out in the same cycle.
//   undefined -> sum_out always shows the stored value.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mac_out         MAC result to store
//   mac_out_en      MAC write strobe
//   mac_write_addr  entry written by mac_out
//   psum_read_addr  entry presented on sum_out
//   sum_out         mem[psum_read_addr] (combinational) -> MAC sum_in
//   drain_start     one-cycle drain request (honoured only in IDLE)
//   drain_valid     drain_data/drain_addr valid
//   drain_data      entry content being drained
//   drain_addr      index of entry being drained
//   drain_ready     global buffer accepts current entry
//   drain_busy      high while draining
//   drain_done      one-cycle pulse after the last entry is accepted
//   wr_drop         sticky: a MAC write was discarded during a drain

// One psum entry. Write and clear never coincide: writes only land in IDLE,
// clears only in DRAIN.
module rf_psum_entry #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         clr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (wr_en) q <= wr_data;
    else if (clr)   q <= '0;
  end
endmodule

module rf_psum_drain #(
  parameter int OUT_BITWIDTH       = 16,
  parameter int PSUM_ADDR_BITWIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OUT_BITWIDTH-1:0]       mac_out,
  input  logic                          mac_out_en,
  input  logic [PSUM_ADDR_BITWIDTH-1:0] mac_write_addr,
  input  logic [PSUM_ADDR_BITWIDTH-1:0] psum_read_addr,
  output logic [OUT_BITWIDTH-1:0]       sum_out,
  input  logic                          drain_start,
  output logic                          drain_valid,
  output logic [OUT_BITWIDTH-1:0]       drain_data,
  output logic [PSUM_ADDR_BITWIDTH-1:0] drain_addr,
  input  logic                          drain_ready,
  output logic                          drain_busy,
  output logic                          drain_done,
  output logic                          wr_drop
);
  localparam int DEPTH = 2 ** PSUM_ADDR_BITWIDTH;
  localparam logic [PSUM_ADDR_BITWIDTH-1:0] LAST = PSUM_ADDR_BITWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [PSUM_ADDR_BITWIDTH-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0][OUT_BITWIDTH-1:0] mem;

  logic wr_ok;    // MAC write accepted this cycle
  logic accept;   // drain handshake this cycle

  assign wr_ok  = mac_out_en && (state_q == IDLE);
  assign accept = (state_q == DRAIN) && drain_ready;

  // Storage: one entry instance per address.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic hit_wr, hit_clr;
    assign hit_wr  = wr_ok  && (mac_write_addr == PSUM_ADDR_BITWIDTH'(i));
    assign hit_clr = accept && (ptr_q          == PSUM_ADDR_BITWIDTH'(i));
    rf_psum_entry #(.W(OUT_BITWIDTH)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (hit_wr),
      .clr     (hit_clr),
      .wr_data (mac_out),
      .q       (mem[i])
    );
  end

  // State / pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    drain_valid = 1'b0;
    drain_busy  = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drain_start) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
        drain_valid = 1'b1;
        drain_busy  = 1'b1;
        if (drain_ready) begin
          ptr_d = ptr_q + PSUM_ADDR_BITWIDTH'(1);
          if (ptr_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        drain_done = 1'b1;
        ptr_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign drain_addr = ptr_q;
  assign drain_data = mem[ptr_q];

`ifdef RF_PSUM_BYPASS_EN
  // Forward a same-cycle write so back-to-back accumulation into one entry
  // sees the fresh value without a bubble.
  assign sum_out = (wr_ok && (mac_write_addr == psum_read_addr)) ? mac_out
                                                                 : mem[psum_read_addr];
`else
  assign sum_out = mem[psum_read_addr];
`endif

  // Sticky drop flag: any MAC write outside IDLE is lost.
  always_ff @(posedge clk) begin
    if (rst)                                  wr_drop <= 1'b0;
    else if (mac_out_en && state_q != IDLE)   wr_drop <= 1'b1;
  end
endmodule
